bitser_min_ctrl: RTL and testbench

Sequencer for the bit-serial minimum-select datapath. Accepts NUM operand words through a valid/ready handshake and shifts them MSB-first, one bit position per clock. Keeps an "alive" candidate mask and streams out the minimum value bit by bit. Never compares whole words. Sits between the operand producer and any consumer of the serial minimum stream and the final winner index.

---
 rtl/bitser_min_ctrl_pkg.sv | 4 +
 rtl/bitser_min_ctrl_lsb_prio_enc.sv | 16 +
 rtl/bitser_min_ctrl.sv | 104 ++++++++++
 tb/tb_bitser_min_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bitser_min_ctrl_pkg.sv
// bitser_pkg: shared types for the bit-serial minimum-select sequencer.
package bitser_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bitser_min_ctrl_lsb_prio_enc.sv
// lsb_prio_enc: index of the lowest set bit of an N-bit mask, plus a nonzero flag.
module lsb_prio_enc #(
    parameter int N = 3,
    localparam int IW = N > 2 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    output logic [IW-1:0] idx,
    output logic          valid
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (mask[i]) idx = IW'(i);
        valid = |mask;
    end
endmodule

// File: rtl/bitser_min_ctrl.sv
// bitser_min_ctrl: streams the minimum of NUM operands MSB-first by narrowing an alive mask
// one bit position per clock; whole words are never compared.
module bitser_min_ctrl
    import bitser_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NUM = 3,
    localparam int IDXW = NUM > 2 ? $clog2(NUM) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM*WIDTH-1:0] in_data,
    output logic                 ser_valid,
    output logic                 ser_bit,
    output logic                 ser_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_min,
    output logic [IDXW-1:0]      out_idx,
    output logic [NUM-1:0]       out_mask
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef logic [NUM-1:0] mask_t;
    typedef logic [WIDTH-1:0] word_t;

    state_t state, nxt;
    word_t [NUM-1:0] sh;
    mask_t alive, msb, zeros, alive_nxt;
    logic [CW-1:0] cnt;
    logic [IDXW-1:0] enc_idx;
    logic enc_valid;

    for (genvar k = 0; k < NUM; k++) begin : g_msb
        assign msb[k] = sh[k][WIDTH-1];
    end

    // Only narrow when some alive operand has a 0 here, so alive never empties.
    assign zeros = alive & ~msb;
    assign alive_nxt = |zeros ? zeros : alive;

    lsb_prio_enc #(.N(NUM)) u_enc (
        .mask(alive_nxt),
        .idx(enc_idx),
        .valid(enc_valid)
    );

    always_comb begin
        nxt = state;
        in_ready = 1'b0;
        ser_valid = 1'b0;
        ser_bit = 1'b0;
        ser_last = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                nxt = in_valid ? SHIFT : IDLE;
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_bit = ~|zeros;
                ser_last = cnt == '0;
                nxt = cnt == '0 ? DONE : SHIFT;
            end
            DONE: begin
                out_valid = 1'b1;
                nxt = out_ready ? IDLE : DONE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sh <= '0;
            alive <= '0;
            cnt <= '0;
            out_min <= '0;
            out_idx <= '0;
            out_mask <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && in_valid) begin
                sh <= in_data;
                alive <= '1;
                cnt <= CW'(WIDTH - 1);
                out_min <= '0;
            end else if (state == SHIFT) begin
                for (int k = 0; k < NUM; k++)
                    sh[k] <= sh[k] << 1;
                alive <= alive_nxt;
                out_min <= WIDTH'({out_min, ser_bit});
                cnt <= cnt - CW'(1);
                if (cnt == '0) begin
                    out_mask <= alive_nxt;
                    out_idx <= enc_valid ? enc_idx : '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_bitser_min_ctrl.sv
// tb_bitser_min_ctrl: directed and random operand sets checked against a plain min/tie model.
module tb_bitser_min_ctrl;
    localparam int WIDTH = 8;
    localparam int NUM = 3;
    localparam int IDXW = 2;
    typedef logic [WIDTH-1:0] word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [NUM*WIDTH-1:0] in_data = '0;
    logic in_ready, ser_valid, ser_bit, ser_last, out_valid;
    logic [WIDTH-1:0] out_min;
    logic [IDXW-1:0] out_idx;
    logic [NUM-1:0] out_mask;

    int tests = 0;
    int fails = 0;
    word_t e_min;
    logic [IDXW-1:0] e_idx;
    logic [NUM-1:0] e_mask;

    bitser_min_ctrl #(.WIDTH(WIDTH), .NUM(NUM)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .ser_valid(ser_valid),
        .ser_bit(ser_bit),
        .ser_last(ser_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_min(out_min),
        .out_idx(out_idx),
        .out_mask(out_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input word_t a, input word_t b, input word_t c);
        word_t ops[NUM];
        bit found;
        ops = '{a, b, c};
        e_min = ops[0];
        for (int k = 1; k < NUM; k++)
            if (ops[k] < e_min) e_min = ops[k];
        e_mask = '0;
        e_idx = '0;
        found = 0;
        for (int k = 0; k < NUM; k++)
            if (ops[k] == e_min) begin
                e_mask[k] = 1'b1;
                if (!found) e_idx = IDXW'(k);
                found = 1;
            end
    endtask

    task automatic start_op(input word_t a, input word_t b, input word_t c);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", in_ready, 1);
        in_data = {c, b, a};
        in_valid = 1'b1;
        model(a, b, c);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic serial(input int nbits, input bit pulse);
        for (int i = 0; i < nbits; i++) begin
            chk("ser_valid", ser_valid, 1);
            chk("ser_bit", ser_bit, e_min[WIDTH-1-i]);
            chk("ser_last", ser_last, i == WIDTH - 1);
            chk("in_ready_shift", in_ready, 0);
            if (pulse && i == 2) begin
                in_valid = 1'b1;
                in_data = '0;
            end
            if (i == 3) in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic finish_op(input int hold);
        chk("out_valid", out_valid, 1);
        chk("out_min", out_min, e_min);
        chk("out_idx", out_idx, e_idx);
        chk("out_mask", out_mask, e_mask);
        chk("in_ready_done", in_ready, 0);
        if (hold > 0) begin
            out_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", out_valid, 1);
                chk("hold_min", out_min, e_min);
                chk("hold_idx", out_idx, e_idx);
                chk("hold_mask", out_mask, e_mask);
                chk("hold_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        chk("release_min_kept", out_min, e_min);
    endtask

    task automatic run_op(input word_t a, input word_t b, input word_t c, input int hold, input bit pulse);
        start_op(a, b, c);
        serial(WIDTH, pulse);
        finish_op(hold);
    endtask

    initial begin
        word_t a, b, c, got;
        word_t exp_q[$];
        int acc[$];
        int nres, nser;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_ser_bit", ser_bit, 0);
        chk("rst_ser_last", ser_last, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_min", out_min, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_mask", out_mask, 0);
        rst = 1'b0;
        @(negedge clk);
        run_op(8'd33, 8'd36, 8'd43, 0, 0);
        run_op(8'd200, 8'd100, 8'd5, 0, 0);
        run_op(8'd36, 8'd36, 8'd43, 0, 0);
        run_op(8'd255, 8'd255, 8'd255, 0, 0);
        run_op(8'd10, 8'd20, 8'd30, 3, 1);
        start_op(8'd50, 8'd60, 8'd70);
        serial(3, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ser_valid", ser_valid, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_min", out_min, 0);
        run_op(8'd7, 8'd3, 8'd9, 0, 0);
        repeat (30) begin
            a = word_t'($urandom);
            b = $urandom_range(0, 3) == 0 ? a : word_t'($urandom);
            c = $urandom_range(0, 3) == 0 ? b : word_t'($urandom);
            run_op(a, b, c, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
        model(8'd90, 8'd17, 8'd64);
        exp_q.push_back(e_min);
        model(8'd128, 8'd129, 8'd4);
        exp_q.push_back(e_min);
        got = '0;
        nres = 0;
        nser = 0;
        in_data = {8'd64, 8'd17, 8'd90};
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 3 * (WIDTH + 2) + 4; cyc++) begin
            if (ser_valid) begin
                got = WIDTH'({got, ser_bit});
                if (ser_last) begin
                    if (nser < 2) chk("b2b_serial", got, exp_q[nser]);
                    nser++;
                end
            end
            if (out_valid) begin
                if (nres < 2) chk("b2b_min", out_min, exp_q[nres]);
                nres++;
            end
            if (in_ready && in_valid) begin
                acc.push_back(cyc);
                @(posedge clk);
                #1;
                if (acc.size() == 1) in_data = {8'd4, 8'd129, 8'd128};
                else in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b_accepts", acc.size(), 2);
        if (acc.size() == 2) chk("b2b_gap", acc[1] - acc[0], WIDTH + 2);
        chk("b2b_serial_count", nser, 2);
        chk("b2b_result_count", nres, 2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
